spi_bus_arbiter: RTL and testbench

- Shares one physical SPI bus (e.g. application flash on appspi_clk/d0/d1/cs) between NumReq SPI host requesters, such as a boot-copy engine and a CPU-driven SPI host.
- Sits between the requesters and the pin-level outputs that feed the top-level pin assignments.
- Grants ownership round-robin, holds a grant for the owner's whole transaction, and enforces a minimum chip-select idle gap between owners.
- A watchdog revokes ownership from a requester that holds the bus too long.

---
 rtl/spi_bus_arbiter.sv | 170 +++++++++++++++++
 tb/tb_spi_bus_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_bus_arbiter.sv
// Round-robin owner arbitration for one shared SPI bus. Registers the owner's
// pins, enforces a CS-high gap between owners, and revokes over-long grants.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | bus free, pins idle, pick next eligible requester
// GRANT | owner's SCLK/COPI/CS registered onto the bus
// GAP   | CS held high for GapCycles before the next arbitration
module spi_bus_arbiter #(
  parameter int NumReq        = 2,
  parameter int GapCycles     = 4,
  parameter int TimeoutCycles = 65536,
  parameter int OwnerW        = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumReq-1:0] req_i,
  output logic [NumReq-1:0] gnt_o,
  input  logic [NumReq-1:0] sclk_i,
  input  logic [NumReq-1:0] copi_i,
  input  logic [NumReq-1:0] cs_ni,
  output logic [NumReq-1:0] cipo_o,
  output logic              spi_sclk_o,
  output logic              spi_copi_o,
  output logic              spi_cs_no,
  input  logic              spi_cipo_i,
  output logic              busy_o,
  output logic [OwnerW-1:0] owner_o,
  output logic              timeout_o
);

  localparam int TmoW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam int GapW = (GapCycles > 1) ? $clog2(GapCycles) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
  localparam logic [GapW-1:0] GapLast = GapW'(GapCycles - 1);
  localparam bit TmoEn = (TimeoutCycles != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  state_e            state_q;
  logic [NumReq-1:0] gnt_q;
  logic [OwnerW-1:0] owner_q;
  logic [OwnerW-1:0] ptr_q;
  logic [NumReq-1:0] lockout_q;
  logic [NumReq-1:0] lockout_d;
  logic [TmoW-1:0]   tmo_cnt_q;
  logic [GapW-1:0]   gap_cnt_q;
  logic              timeout_q;
  logic              sclk_q;
  logic              copi_q;
  logic              cs_n_q;

  logic [NumReq-1:0] eligible;
  logic              found;
  logic [OwnerW-1:0] winner;
  logic [OwnerW-1:0] ptr_next;
  logic              owner_req;
  logic              revoke;
  int                idx;

  assign eligible  = req_i & ~lockout_q;
  assign owner_req = req_i[owner_q];

  // Requester dropping its request in the same cycle as the timeout wins.
  assign revoke = (state_q == GRANT) && owner_req && TmoEn && (tmo_cnt_q == TmoLast);

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < NumReq; k++) begin
      idx = (int'(ptr_q) + k) % NumReq;
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = OwnerW'(idx);
      end
    end
  end

  assign ptr_next = (int'(winner) == NumReq - 1) ? '0 : winner + 1'b1;

  always_comb begin
    lockout_d = lockout_q & req_i;
    if (revoke) begin
      lockout_d[owner_q] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      lockout_q <= '0;
      tmo_cnt_q <= '0;
      gap_cnt_q <= '0;
      timeout_q <= 1'b0;
      sclk_q    <= 1'b0;
      copi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
    end else begin
      timeout_q <= 1'b0;
      lockout_q <= lockout_d;
      case (state_q)
        IDLE: begin
          sclk_q <= 1'b0;
          copi_q <= 1'b0;
          cs_n_q <= 1'b1;
          if (found) begin
            state_q   <= GRANT;
            gnt_q     <= NumReq'(1) << winner;
            owner_q   <= winner;
            ptr_q     <= ptr_next;
            tmo_cnt_q <= '0;
          end
        end
        GRANT: begin
          tmo_cnt_q <= tmo_cnt_q + 1'b1;
          if (!owner_req || revoke) begin
            // Pins go idle on the way out so a revoked owner cannot keep CS low.
            state_q   <= GAP;
            gnt_q     <= '0;
            gap_cnt_q <= GapLast;
            timeout_q <= revoke;
            sclk_q    <= 1'b0;
            copi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
          end else begin
            sclk_q <= sclk_i[owner_q];
            copi_q <= copi_i[owner_q];
            cs_n_q <= cs_ni[owner_q];
          end
        end
        GAP: begin
          sclk_q <= 1'b0;
          copi_q <= 1'b0;
          cs_n_q <= 1'b1;
          if (gap_cnt_q == '0) begin
            state_q <= IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          sclk_q  <= 1'b0;
          copi_q  <= 1'b0;
          cs_n_q  <= 1'b1;
        end
      endcase
    end
  end

  assign gnt_o      = gnt_q;
  assign owner_o    = owner_q;
  assign busy_o     = (state_q != IDLE);
  assign timeout_o  = timeout_q;
  assign spi_sclk_o = sclk_q;
  assign spi_copi_o = copi_q;
  assign spi_cs_no  = cs_n_q;
  // Only the granted requester sees bus CIPO; gnt_q is zero outside GRANT.
  assign cipo_o     = gnt_q & {NumReq{spi_cipo_i}};

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter: grant latency, pin routing, round-robin,
// CS gap, watchdog revoke/lockout, async reset, and drop/timeout coincidence.
module tb_spi_bus_arbiter;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [1:0] req;
  logic [1:0] gnt_o;
  logic [1:0] sclk;
  logic [1:0] copi;
  logic [1:0] cs_n;
  logic [1:0] cipo_o;
  logic       spi_sclk_o;
  logic       spi_copi_o;
  logic       spi_cs_no;
  logic       spi_cipo;
  logic       busy_o;
  logic       owner_o;
  logic       timeout_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt;
  int pulses;
  int bad;

  spi_bus_arbiter #(
    .NumReq(2),
    .GapCycles(4),
    .TimeoutCycles(16)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .req_i(req),
    .gnt_o(gnt_o),
    .sclk_i(sclk),
    .copi_i(copi),
    .cs_ni(cs_n),
    .cipo_o(cipo_o),
    .spi_sclk_o(spi_sclk_o),
    .spi_copi_o(spi_copi_o),
    .spi_cs_no(spi_cs_no),
    .spi_cipo_i(spi_cipo),
    .busy_o(busy_o),
    .owner_o(owner_o),
    .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered on the first GRANT cycle of idx; holds 10 grant cycles, drops req
  // for one cycle, then measures CS-high time until the next grant.
  task automatic hold_and_release(input int idx, input logic [1:0] exp_gnt);
    int hi;
    int k;
    cs_n = 2'b11;
    cs_n[idx] = 1'b0;
    repeat (9) tick();
    check("hold_cs_low", {31'd0, spi_cs_no}, 32'd0);
    cs_n = 2'b11;
    req[idx] = 1'b0;
    tick();
    req[idx] = 1'b1;
    hi = 0;
    k = 0;
    while (gnt_o == 2'b00 && k < 20) begin
      if (spi_cs_no) hi++;
      tick();
      k++;
    end
    check("rr_next_gnt", {30'd0, gnt_o}, {30'd0, exp_gnt});
    check("gap_cs_high_ge4", {31'd0, (hi >= 4)}, 32'd1);
  endtask

  initial begin
    rst_ni = 1'b0;
    req = 2'b00;
    sclk = 2'b00;
    copi = 2'b00;
    cs_n = 2'b11;
    spi_cipo = 1'b0;
    repeat (2) tick();
    check("rst_gnt", {30'd0, gnt_o}, 32'd0);
    check("rst_cs", {31'd0, spi_cs_no}, 32'd1);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_owner", {31'd0, owner_o}, 32'd0);
    check("rst_timeout", {31'd0, timeout_o}, 32'd0);
    rst_ni = 1'b1;
    tick();

    // First grant and pin routing
    req = 2'b01;
    cs_n = 2'b10;
    sclk = 2'b01;
    copi = 2'b01;
    tick();
    check("t1_gnt", {30'd0, gnt_o}, 32'd1);
    check("t1_owner", {31'd0, owner_o}, 32'd0);
    check("t1_busy", {31'd0, busy_o}, 32'd1);
    check("t1_cs_still_idle", {31'd0, spi_cs_no}, 32'd1);
    tick();
    check("t1_cs_low", {31'd0, spi_cs_no}, 32'd0);
    check("t1_sclk", {31'd0, spi_sclk_o}, 32'd1);
    check("t1_copi", {31'd0, spi_copi_o}, 32'd1);
    spi_cipo = 1'b1;
    #1;
    check("t1_cipo", {30'd0, cipo_o}, 32'd1);
    req = 2'b11;
    sclk = 2'b10;
    tick();
    check("nonowner_gnt", {30'd0, gnt_o}, 32'd1);
    check("nonowner_sclk", {31'd0, spi_sclk_o}, 32'd0);
    cs_n = 2'b11;
    tick();
    check("owner_cs_release", {31'd0, spi_cs_no}, 32'd1);

    // Owner 0 drops while requester 1 waits
    req = 2'b10;
    sclk = 2'b00;
    copi = 2'b00;
    tick();
    check("drop_gnt", {30'd0, gnt_o}, 32'd0);
    check("drop_busy", {31'd0, busy_o}, 32'd1);
    check("gap_cipo", {30'd0, cipo_o}, 32'd0);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (gnt_o != 2'b00 || spi_cs_no != 1'b1 || busy_o != 1'b1) bad++;
    end
    check("gap_4_cycles", bad, 32'd0);
    tick();
    check("idle_busy", {31'd0, busy_o}, 32'd0);
    check("idle_gnt", {30'd0, gnt_o}, 32'd0);
    tick();
    check("gnt1_after_idle", {30'd0, gnt_o}, 32'd2);
    check("owner1", {31'd0, owner_o}, 32'd1);

    // Round-robin alternation
    req = 2'b11;
    hold_and_release(1, 2'b01);
    hold_and_release(0, 2'b10);
    hold_and_release(1, 2'b01);
    req = 2'b00;
    cs_n = 2'b11;
    repeat (6) tick();
    check("quiesce_busy", {31'd0, busy_o}, 32'd0);

    // Watchdog revoke and lockout
    req = 2'b01;
    cs_n = 2'b10;
    tick();
    check("tmo_gnt", {30'd0, gnt_o}, 32'd1);
    cnt = 0;
    while (gnt_o != 2'b00 && cnt < 30) begin
      cnt++;
      tick();
    end
    check("tmo_grant_len", cnt, 32'd16);
    check("tmo_pulse", {31'd0, timeout_o}, 32'd1);
    check("tmo_cs", {31'd0, spi_cs_no}, 32'd1);
    pulses = 1;
    bad = 0;
    for (int i = 0; i < 22; i++) begin
      tick();
      if (timeout_o) pulses++;
      if (gnt_o != 2'b00) bad++;
    end
    check("tmo_single_pulse", pulses, 32'd1);
    check("lockout_no_regrant", bad, 32'd0);
    req = 2'b00;
    tick();
    req = 2'b01;
    tick();
    check("lockout_cleared_gnt", {30'd0, gnt_o}, 32'd1);
    tick();
    check("regrant_cs_low", {31'd0, spi_cs_no}, 32'd0);

    // Async reset mid-grant
    rst_ni = 1'b0;
    #1;
    check("arst_cs", {31'd0, spi_cs_no}, 32'd1);
    check("arst_gnt", {30'd0, gnt_o}, 32'd0);
    check("arst_busy", {31'd0, busy_o}, 32'd0);
    tick();
    rst_ni = 1'b1;
    req = 2'b10;
    cs_n = 2'b11;
    tick();
    check("post_rst_gnt", {30'd0, gnt_o}, 32'd2);
    check("post_rst_owner", {31'd0, owner_o}, 32'd1);

    // Request drop coincides with timeout: no pulse, no lockout
    repeat (15) tick();
    check("coinc_still_gnt", {30'd0, gnt_o}, 32'd2);
    req = 2'b00;
    tick();
    check("coinc_gnt", {30'd0, gnt_o}, 32'd0);
    check("coinc_busy", {31'd0, busy_o}, 32'd1);
    pulses = timeout_o ? 1 : 0;
    req = 2'b10;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (timeout_o) pulses++;
    end
    check("coinc_no_pulse", pulses, 32'd0);
    check("coinc_no_lockout", {30'd0, gnt_o}, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
